seq_detector: RTL and testbench

// - Serial bit-stream pattern detector. Mealy FSM, overlapping matches.
// - Samples 1-bit din on each rising clk edge.
// - z flags the cycle whose din completes a 4-bit pattern (default 0001).
// - Sits between a serial data source and downstream event logic.

---
 rtl/seq_detector.sv | 124 ++++++++++++
 tb/tb_seq_detector.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//
// Serial bit-stream pattern detector built as a Mealy FSM. Matches may
// overlap. One bit of din is sampled on every rising edge of clk. z is high
// in the same cycle as the din bit that completes PATTERN. PATTERN bit 3
// arrives first and bit 0 arrives last.
//
// The state is the number of pattern bits matched so far (S0..S3). The
// transition table is not written out by hand. It is derived from PATTERN
// with the usual overlap (failure-function) rule, so changing the parameter
// also gives a correct table.
//
// Optional feature macro: SEQ_MATCH_COUNT_EN
//   When defined, the design adds an 8-bit saturating count of matches.
//
// Ports
//   clk        in   1  system clock; all state changes on the rising edge
//   reset      in   1  synchronous reset, active-low (0 = reset)
//   din        in   1  serial data bit, one per clk cycle
//   z          out  1  Mealy match flag, combinational from state and din
//   match_cnt  out  8  saturating match count (SEQ_MATCH_COUNT_EN only)
// ---------------------------------------------------------------------------
module seq_detector #(
   parameter logic [3:0] PATTERN = 4'b0001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   output logic       z
`ifdef SEQ_MATCH_COUNT_EN
   ,
   output logic [7:0] match_cnt
`endif
);

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   // Given k matched bits and a new bit, this returns the length of the
   // longest proper prefix of PATTERN that is also a suffix of the bits seen.
   // The result is capped at 3. A completed match therefore falls back to
   // the overlap point and does not reach a 4th state.
   function automatic logic [1:0] advance(input logic [1:0] k, input logic bit_in);
      logic [3:0] seq;
      logic [1:0] best;
      logic [1:0] pos;
      logic       ok;
      int         len;
      seq  = '0;
      best = '0;
      len  = int'(k) + 1;
      for (int i = 0; i < 4; i++) begin
         if (i < len - 1) begin
            seq[i] = PATTERN[2'(3 - i)];
         end else if (i == len - 1) begin
            seq[i] = bit_in;
         end
      end
      for (int l = 1; l <= 3; l++) begin
         if (l <= len) begin
            ok = 1'b1;
            for (int i = 0; i < 3; i++) begin
               if (i < l) begin
                  pos = 2'(len - l + i);
                  if (seq[pos] != PATTERN[2'(3 - i)]) begin
                     ok = 1'b0;
                  end
               end
            end
            if (ok) begin
               best = 2'(l);
            end
         end
      end
      return best;
   endfunction

   // State register. Reset wins over din and discards any partial match.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S0;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and Mealy output. z is gated by reset, so it stays low for
   // the whole time reset is held.
   always_comb begin
      next_state = S0;
      z          = 1'b0;
      case (state)
         S0:      next_state = state_t'(advance(2'd0, din));
         S1:      next_state = state_t'(advance(2'd1, din));
         S2:      next_state = state_t'(advance(2'd2, din));
         S3:      next_state = state_t'(advance(2'd3, din));
         default: next_state = S0;
      endcase
      if (reset && (state == S3) && (din == PATTERN[0])) begin
         z = 1'b1;
      end
   end

`ifdef SEQ_MATCH_COUNT_EN
   // Match counter. It stops at 255 rather than wrapping, so a large count
   // is never mistaken for a small one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         match_cnt <= 8'd0;
      end else if (z && (match_cnt != 8'hFF)) begin
         match_cnt <= match_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
//
// Testbench for seq_detector.
//
// The stimulus side drives reset and din shortly after each rising edge. It
// pushes the expected z (and match count) onto a scoreboard queue. A
// separate monitor pops one entry per cycle on the falling edge and compares
// it with the DUT.
//
// The reference model keeps the raw bits received since the last reset. A
// match is the last four of those bits being equal to the pattern.
//
// Set SEQ_MATCH_COUNT_EN to exercise the counter.
// ---------------------------------------------------------------------------
module tb_seq_detector;

   localparam logic [3:0] PAT = 4'b0001;

   typedef struct {
      logic z;
      int   cnt;
      logic cnt_valid;
   } exp_t;

   logic clk;
   logic reset;
   logic din;
   logic z;
`ifdef SEQ_MATCH_COUNT_EN
   logic [7:0] match_cnt;
`endif

   exp_t scoreboard[$];
   logic history[$];
   int   model_cnt;
   logic model_cnt_known;
   int   vectors;
   int   miscompares;
   logic stim_done;

   seq_detector #(.PATTERN(PAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .din      (din),
      .z        (z)
`ifdef SEQ_MATCH_COUNT_EN
      ,
      .match_cnt(match_cnt)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle, predict the DUT response, and push it to the scoreboard.
   // The model is then advanced as of the coming rising edge.
   task automatic applyStimulus(input logic r, input logic d);
      exp_t e;
      int   n;
      @(posedge clk);
      #1;
      reset = r;
      din   = d;
      n = history.size();
      e.z = r && (n >= 3) &&
            ({history[n-3], history[n-2], history[n-1], d} == PAT);
      e.cnt       = model_cnt;
      e.cnt_valid = model_cnt_known;
      scoreboard.push_back(e);
      if (!r) begin
         history.delete();
         model_cnt       = 0;
         model_cnt_known = 1'b1;
      end else begin
         history.push_back(d);
         if (history.size() > 8) begin
            void'(history.pop_front());
         end
         if (e.z && model_cnt < 255) begin
            model_cnt++;
         end
      end
   endtask

   task automatic applySeq(input logic [31:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         applyStimulus(1'b1, bits[i]);
      end
   endtask

   // Compare one scoreboard entry against the DUT outputs.
   task automatic checkOutput(input exp_t e);
      vectors++;
      if (z !== e.z) begin
         miscompares++;
         $display("[TB] FAIL z at %0t: got %b expected %b", $time, z, e.z);
      end
`ifdef SEQ_MATCH_COUNT_EN
      if (e.cnt_valid && (int'(match_cnt) != e.cnt)) begin
         miscompares++;
         $display("[TB] FAIL match_cnt at %0t: got %0d expected %0d",
                  $time, match_cnt, e.cnt);
      end
`endif
   endtask

   // Monitor: z is valid every cycle, so one entry is popped per falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (scoreboard.size() > 0) begin
            checkOutput(scoreboard.pop_front());
         end
      end
   end

   // Stimulus sequence.
   initial begin
      reset           = 1'b1;
      din             = 1'b0;
      model_cnt       = 0;
      model_cnt_known = 1'b0;
      vectors         = 0;
      miscompares     = 0;
      stim_done       = 1'b0;

      $display("[TB] reset held low with din=1");
      applyStimulus(1'b0, 1'b1);
      $display("[TB] 0001 after reset");
      applySeq(32'b0001, 4);
      applyStimulus(1'b0, 1'b0);
      $display("[TB] 000001, extra zeros hold S3");
      applySeq(32'b000001, 6);
      applyStimulus(1'b0, 1'b1);
      $display("[TB] overlapping stream 00010010001");
      applySeq(32'b00010010001, 11);
      applyStimulus(1'b0, 1'b0);
      $display("[TB] mid-pattern reset discards partial match");
      applySeq(32'b000, 3);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      $display("[TB] randomized stream");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0));
      end
`ifdef SEQ_MATCH_COUNT_EN
      $display("[TB] counter saturation with 300 back-to-back groups");
      applyStimulus(1'b0, 1'b0);
      for (int g = 0; g < 300; g++) begin
         applySeq(32'b0001, 4);
      end
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
`endif
      @(posedge clk);
      stim_done = 1'b1;
   end

   // Drain the scoreboard within a bounded number of cycles, then summarize.
   initial begin
      wait (stim_done == 1'b1);
      for (int c = 0; c < 10 && scoreboard.size() > 0; c++) begin
         @(negedge clk);
         #1;
      end
      if (scoreboard.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound.
   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not complete, got %0d vectors", vectors);
      $fatal(1, "[TB] timeout");
   end

endmodule
